// File: rtl/sar_scan_pkg.sv
// Shared types and constants for the SAR scan controller:
// FSM state encoding, xdata write-strobe bit positions, default settle time.
package sar_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SETTLE,
        ST_SAMPLE,
        ST_NEXT
    } scan_state_e;

    localparam int unsigned WR_DACEN_LO     = 0;
    localparam int unsigned WR_SAREN_LO     = 1;
    localparam int unsigned WR_DACV_LO_BASE = 2;   // DACV8..15 -> ch0..7
    localparam int unsigned WR_DACEN_HI     = 10;
    localparam int unsigned WR_SAREN_HI     = 11;
    localparam int unsigned WR_DACV_HI_BASE = 12;  // DACV16..17 -> ch8..9
    localparam int unsigned WR_STROBES      = 14;

    localparam int unsigned SETTLE_DEFAULT  = 4;

    function automatic int unsigned dacv_strobe(input int unsigned ch);
        return (ch < 8) ? (WR_DACV_LO_BASE + ch) : (WR_DACV_HI_BASE + ch - 8);
    endfunction

endpackage

// File: rtl/sar_bit_engine.sv
// Successive-approximation datapath: result accumulator, one-hot trial bit
// and DAC settle counter, stepped by start/count/sample from the scan FSM.
module sar_bit_engine #(
    parameter int unsigned DW     = 8,
    parameter int unsigned SETTLE = 4
) (
    input  logic          clk,
    input  logic          rrstz,
    input  logic          start_i,
    input  logic          count_i,
    input  logic          sample_i,
    input  logic          cmp_i,
    output logic [DW-1:0] code_o,
    output logic [DW-1:0] result_o,
    output logic          settled_o,
    output logic          last_o
);

    localparam int unsigned   CNTW      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(SETTLE - 1);
    localparam logic [DW-1:0] TRIAL_MSB = DW'(1) << (DW - 1);

    logic [DW-1:0]   acc_q, acc_d;
    logic [DW-1:0]   trial_q, trial_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    assign code_o    = acc_q | trial_q;
    assign result_o  = acc_q | (cmp_i ? trial_q : '0);
    assign settled_o = (cnt_q == '0);
    assign last_o    = trial_q[0];

    always_comb begin
        acc_d   = acc_q;
        trial_d = trial_q;
        cnt_d   = cnt_q;
        if (start_i) begin
            acc_d   = '0;
            trial_d = TRIAL_MSB;
            cnt_d   = CNT_LOAD;
        end else if (sample_i) begin
            acc_d   = result_o;
            trial_d = trial_q >> 1;
            cnt_d   = CNT_LOAD;
        end else if (count_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rrstz) begin
            acc_q   <= '0;
            trial_q <= '0;
            cnt_q   <= '0;
        end else begin
            acc_q   <= acc_d;
            trial_q <= trial_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/sar_scan_ctl.sv
// Scans the enabled DAC/comparator channels in ascending order, running an
// 8-bit SAR conversion or a single threshold compare on each; owns the DAC xdata registers.
module sar_scan_ctl
    import sar_scan_pkg::*;
#(
    parameter int unsigned NCH    = 10,
    parameter int unsigned DW     = 8,
    parameter int unsigned SETTLE = SETTLE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rrstz,
    input  logic [WR_STROBES-1:0] regx_wrdac,
    input  logic [7:0]            regx_wdat,
    input  logic                  scan_go,
    input  logic                  scan_cont,
    input  logic                  scan_abort,
    input  logic                  cmp_i,
    output logic [DW*NCH-1:0]     dac_r_vs,
    output logic [NCH-1:0]        dac_comp,
    output logic [NCH-1:0]        r_dac_en,
    output logic [NCH-1:0]        r_sar_en,
    output logic [NCH-1:0]        dac_sel,
    output logic [DW-1:0]         dac_code,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned   CW        = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [DW-1:0] TRIAL_MSB = DW'(1) << (DW - 1);

    scan_state_e             state_q, state_d;
    logic [CW-1:0]           ch_q, ch_d;
    logic [NCH-1:0]          mask_q, mask_d;
    logic                    mode_q, mode_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic [NCH-1:0][DW-1:0]  vs_q;
    logic [NCH-1:0]          comp_q;
    logic [NCH-1:0]          en_q;
    logic [NCH-1:0]          saren_q;

    logic                    eng_start, eng_count, eng_sample;
    logic [DW-1:0]           eng_code, eng_result;
    logic                    eng_settled, eng_last;
    logic                    store_en, comp_en;
    logic [NCH-1:0]          ch_onehot;

    function automatic logic [CW-1:0] first_ch(input logic [NCH-1:0] v);
        first_ch = '0;
        for (int unsigned i = NCH; i > 0; i--) begin
            if (v[i-1]) first_ch = CW'(i - 1);
        end
    endfunction

    assign ch_onehot = NCH'(1) << ch_q;

    sar_bit_engine #(
        .DW     (DW),
        .SETTLE (SETTLE)
    ) u_engine (
        .clk       (clk),
        .rrstz     (rrstz),
        .start_i   (eng_start),
        .count_i   (eng_count),
        .sample_i  (eng_sample),
        .cmp_i     (cmp_i),
        .code_o    (eng_code),
        .result_o  (eng_result),
        .settled_o (eng_settled),
        .last_o    (eng_last)
    );

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        mask_d     = mask_q;
        mode_d     = mode_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        eng_start  = 1'b0;
        eng_count  = 1'b0;
        eng_sample = 1'b0;
        store_en   = 1'b0;
        comp_en    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (scan_go) begin
                    if (en_q == '0) begin
                        done_d = 1'b1;
                    end else begin
                        mask_d  = en_q;
                        ch_d    = first_ch(en_q);
                        busy_d  = 1'b1;
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                mode_d    = saren_q[ch_q];
                eng_start = 1'b1;
                state_d   = ST_SETTLE;
            end
            ST_SETTLE: begin
                eng_count = 1'b1;
                if (eng_settled) state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (mode_q && !eng_last) begin
                    eng_sample = 1'b1;
                    state_d    = ST_SETTLE;
                end else begin
                    // Channel retires here so done lines up with the final NEXT cycle.
                    store_en = mode_q;
                    comp_en  = !mode_q;
                    mask_d   = mask_q & ~ch_onehot;
                    done_d   = ((mask_q & ~ch_onehot) == '0);
                    state_d  = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (mask_q != '0) begin
                    ch_d    = first_ch(mask_q);
                    state_d = ST_SETUP;
                end else if (scan_cont && (en_q != '0)) begin
                    mask_d  = en_q;
                    ch_d    = first_ch(en_q);
                    state_d = ST_SETUP;
                end else begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (scan_abort) begin
            state_d  = ST_IDLE;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            store_en = 1'b0;
            comp_en  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rrstz) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            mask_q  <= '0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            mask_q  <= mask_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Scan results are assigned after the CPU writes so they win a same-byte collision.
    always_ff @(posedge clk) begin
        if (!rrstz) begin
            vs_q    <= '0;
            comp_q  <= '0;
            en_q    <= '0;
            saren_q <= '0;
        end else begin
            for (int unsigned c = 0; c < NCH; c++) begin
                if (regx_wrdac[dacv_strobe(c)]) vs_q[c] <= DW'(regx_wdat);
                if (regx_wrdac[(c < 8) ? WR_DACEN_LO : WR_DACEN_HI]) en_q[c] <= regx_wdat[c % 8];
                if (regx_wrdac[(c < 8) ? WR_SAREN_LO : WR_SAREN_HI]) saren_q[c] <= regx_wdat[c % 8];
            end
            if (store_en) vs_q[ch_q] <= eng_result;
            if (comp_en) comp_q[ch_q] <= cmp_i;
        end
    end

    always_comb begin
        dac_sel  = '0;
        dac_code = '0;
        unique case (state_q)
            ST_SETUP: begin
                dac_sel  = ch_onehot;
                dac_code = saren_q[ch_q] ? TRIAL_MSB : vs_q[ch_q];
            end
            ST_SETTLE, ST_SAMPLE: begin
                dac_sel  = ch_onehot;
                dac_code = mode_q ? eng_code : vs_q[ch_q];
            end
            default: ;
        endcase
    end

    assign dac_r_vs = vs_q;
    assign dac_comp = comp_q;
    assign r_dac_en = en_q;
    assign r_sar_en = saren_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_sar_scan_ctl.sv
// Directed bench for sar_scan_ctl with a strict-greater comparator model
// driven from an analog level vin.
module tb_sar_scan_ctl;

    logic        clk = 1'b0;
    logic        rrstz;
    logic [13:0] regx_wrdac;
    logic [7:0]  regx_wdat;
    logic        scan_go, scan_cont, scan_abort, cmp_i;
    logic [79:0] dac_r_vs;
    logic [9:0]  dac_comp, r_dac_en, r_sar_en, dac_sel;
    logic [7:0]  dac_code;
    logic        busy, done;

    logic [7:0]  vin;
    int          n_cmp = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    int          busy_cnt = 0;
    int          base_done, base_busy, n;

    always #5 clk = ~clk;

    // Comparator: 1 when the analog input is strictly above the DAC code.
    assign cmp_i = (vin > dac_code);

    sar_scan_ctl #(.NCH(10), .DW(8), .SETTLE(4)) dut (
        .clk        (clk),
        .rrstz      (rrstz),
        .regx_wrdac (regx_wrdac),
        .regx_wdat  (regx_wdat),
        .scan_go    (scan_go),
        .scan_cont  (scan_cont),
        .scan_abort (scan_abort),
        .cmp_i      (cmp_i),
        .dac_r_vs   (dac_r_vs),
        .dac_comp   (dac_comp),
        .r_dac_en   (r_dac_en),
        .r_sar_en   (r_sar_en),
        .dac_sel    (dac_sel),
        .dac_code   (dac_code),
        .busy       (busy),
        .done       (done)
    );

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt = done_cnt + 1;
        if (busy === 1'b1) busy_cnt = busy_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tickn(input int unsigned k);
        repeat (k) tick();
    endtask

    task automatic wr(input int unsigned idx, input logic [7:0] d);
        regx_wrdac = 14'(1) << idx;
        regx_wdat  = d;
        tick();
        regx_wrdac = '0;
    endtask

    task automatic go();
        scan_go = 1'b1;
        tick();
        scan_go = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rrstz = 1'b0; regx_wrdac = '0; regx_wdat = '0;
        scan_go = 1'b0; scan_cont = 1'b0; scan_abort = 1'b0;
        vin = 8'h5B;
        tickn(3);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sel_code", {dac_sel, dac_code}, 0);
        chk("rst_regs", {dac_r_vs, dac_comp, r_dac_en, r_sar_en}, 0);
        rrstz = 1'b1;
        tick();

        // 1: SAR on ch0; strict compare against level 0x5B converges to 0x5A
        wr(0, 8'h01);
        wr(1, 8'h01);
        chk("t1_en_mode", {r_dac_en, r_sar_en}, {10'h001, 10'h001});
        go();
        chk("t1_setup", {dac_sel, dac_code, 7'd0, busy}, {10'h001, 8'h80, 8'h01});
        n = 1;
        while (done !== 1'b1 && n < 100) begin tick(); n++; end
        chk("t1_done_latency", n, 42);
        chk("t1_result", dac_r_vs[7:0], 8'h5A);
        tick();
        chk("t1_idle", {busy, done}, 0);

        // 2: mask 0x204, SAR on ch2 then compare on ch9 (threshold 0x30)
        wr(0, 8'h04); wr(10, 8'h02); wr(1, 8'h04); wr(11, 8'h00); wr(13, 8'h30);
        base_done = done_cnt;
        go();
        chk("t2_sel_ch2", dac_sel, 10'h004);
        tickn(42);
        chk("t2_sel_ch9", {dac_sel, dac_code}, {10'h200, 8'h30});
        tickn(6);
        chk("t2_done", done, 1);
        chk("t2_comp", dac_comp, 10'h200);
        tick();
        chk("t2_busy_off", busy, 0);
        chk("t2_done_cnt", done_cnt - base_done, 1);
        chk("t2_vs", {dac_r_vs[79:72], dac_r_vs[23:16]}, {8'h30, 8'h5A});

        // 3: empty mask -> done next cycle, never busy
        wr(0, 8'h00); wr(10, 8'h00);
        base_done = done_cnt; base_busy = busy_cnt;
        go();
        chk("t3_done_now", {done, busy}, 2'b10);
        tick();
        chk("t3_done_off", done, 0);
        chk("t3_counts", {done_cnt - base_done, busy_cnt - base_busy}, {32'd1, 32'd0});
        chk("t3_regs", dac_r_vs, 80'h30000000000000_5A005A);

        // 4: abort in 4th SAMPLE of ch0 SAR
        wr(2, 8'h11); wr(0, 8'h01); wr(1, 8'h01);
        base_done = done_cnt;
        go();
        tickn(20);
        chk("t4_in_sample", {dac_sel, busy}, {10'h001, 1'b1});
        scan_abort = 1'b1;
        tick();
        scan_abort = 1'b0;
        chk("t4_aborted", {busy, dac_sel, dac_code}, 0);
        tickn(50);
        chk("t4_no_done", done_cnt - base_done, 0);
        chk("t4_vs_kept", dac_r_vs[7:0], 8'h11);
        scan_go = 1'b1; scan_abort = 1'b1;
        tick();
        scan_go = 1'b0; scan_abort = 1'b0;
        chk("t4_abort_over_go", busy, 0);

        // 5: CPU write colliding with result store; result wins
        go();
        tickn(40);
        regx_wrdac = 14'(1) << 2; regx_wdat = 8'h77;
        tick();
        regx_wrdac = '0;
        chk("t5_done", done, 1);
        chk("t5_scan_wins", dac_r_vs[7:0], 8'h5A);
        tick();
        // compare mode: threshold write mid-SETTLE is tracked live
        wr(1, 8'h00);
        vin = 8'h40;
        go();
        chk("t5_cmp_setup_code", dac_code, 8'h5A);
        tick();
        chk("t5_cmp_settle_code", dac_code, 8'h5A);
        regx_wrdac = 14'(1) << 2; regx_wdat = 8'h30;
        tick();
        regx_wrdac = '0;
        chk("t5_cmp_live_code", dac_code, 8'h30);
        tickn(4);
        chk("t5_cmp_done", done, 1);
        chk("t5_cmp_result", dac_comp, 10'h201);
        tick();

        // 6: continuous mode, mask 0x003 compare-only, 14-cycle passes
        wr(0, 8'h03);
        scan_cont = 1'b1;
        base_done = done_cnt; base_busy = busy_cnt;
        go();
        tickn(13);
        chk("t6_done_p1", {done, busy}, 2'b11);
        tick();
        chk("t6_restart", {dac_sel, done}, {10'h001, 1'b0});
        tickn(13);
        chk("t6_done_p2", done, 1);
        tickn(2);
        scan_cont = 1'b0;
        tickn(12);
        chk("t6_done_p3", done, 1);
        tick();
        chk("t6_stopped", busy, 0);
        chk("t6_counts", {done_cnt - base_done, busy_cnt - base_busy}, {32'd3, 32'd42});
        chk("t6_comp", dac_comp, 10'h203);

        // reset mid-scan
        go();
        tickn(5);
        rrstz = 1'b0;
        tick();
        chk("rst_mid_scan", {busy, dac_sel, r_dac_en}, 0);
        rrstz = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
